// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, absolute/relative/conditional branch and call/return.
// Define PC_SEQ_STACK_EN to build the return stack; without it CALL acts as JMP and RET as INC.
module pc_sequencer #(
  parameter int unsigned           ADDR_WIDTH   = 8,
  parameter int unsigned           STACK_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic [2:0]                         op,
  input  logic                               cond,
  input  logic [ADDR_WIDTH-1:0]              target,
  input  logic [ADDR_WIDTH-1:0]              offset,
  output logic [ADDR_WIDTH-1:0]              pc_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_out,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

  localparam logic [2:0] OP_INC  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BRR  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_BRC  = 3'b101;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] pc_rel;

  // Offset is two's complement, so a plain modulo add gives the signed displacement.
  assign pc_inc = pc_q + ADDR_WIDTH'(1);
  assign pc_rel = pc_q + offset;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else if (en) begin
      pc_q <= pc_d;
    end
  end

  assign pc_out = pc_q;

`ifdef PC_SEQ_STACK_EN

  logic [SP_W-1:0]       sp_q;
  logic [SP_W-1:0]       sp_d;
  logic                  ovf_q;
  logic                  ovf_d;
  logic                  unf_q;
  logic                  unf_d;
  logic                  push;
  logic                  stack_full;
  logic                  stack_empty;
  logic [ADDR_WIDTH-1:0] stack_top;
  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);

  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) begin
        stack_top = stack_q[i];
      end
    end
  end

  always_comb begin
    pc_d  = pc_inc;
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    case (op)
      OP_INC: pc_d = pc_inc;
      OP_JMP: pc_d = target;
      OP_BRR: pc_d = pc_rel;
      OP_CALL: begin
        // A full stack still takes the jump; only the push is dropped.
        pc_d = target;
        if (stack_full) begin
          ovf_d = 1'b1;
        end else begin
          push = 1'b1;
          sp_d = sp_q + SP_W'(1);
        end
      end
      OP_RET: begin
        if (stack_empty) begin
          unf_d = 1'b1;
        end else begin
          pc_d = stack_top;
          sp_d = sp_q - SP_W'(1);
        end
      end
      OP_BRC: pc_d = cond ? pc_rel : pc_inc;
      default: pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (en) begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry contents need no reset; sp_q alone marks which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && en && push) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (sp_q == SP_W'(i)) begin
          stack_q[i] <= pc_inc;
        end
      end
    end
  end

  assign sp_out    = sp_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

`else

  always_comb begin
    pc_d = pc_inc;
    case (op)
      OP_INC:  pc_d = pc_inc;
      OP_JMP:  pc_d = target;
      OP_BRR:  pc_d = pc_rel;
      OP_CALL: pc_d = target;
      OP_RET:  pc_d = pc_inc;
      OP_BRC:  pc_d = cond ? pc_rel : pc_inc;
      default: pc_d = pc_inc;
    endcase
  end

  assign sp_out    = '0;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;

`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer (RESET_VECTOR=0x10, STACK_DEPTH=4).
// Expectations follow whichever way PC_SEQ_STACK_EN is set for the build.
module tb_pc_sequencer;

  localparam int unsigned AW   = 8;
  localparam int unsigned SD   = 4;
  localparam int unsigned SPW  = $clog2(SD + 1);

  localparam logic [2:0] INC  = 3'b000;
  localparam logic [2:0] JMP  = 3'b001;
  localparam logic [2:0] BRR  = 3'b010;
  localparam logic [2:0] CALL = 3'b011;
  localparam logic [2:0] RET  = 3'b100;
  localparam logic [2:0] BRC  = 3'b101;
  localparam logic [2:0] RS6  = 3'b110;
  localparam logic [2:0] RS7  = 3'b111;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic [2:0]     op = INC;
  logic           cond = 1'b0;
  logic [AW-1:0]  target = '0;
  logic [AW-1:0]  offset = '0;
  logic [AW-1:0]  pc_out;
  logic [SPW-1:0] sp_out;
  logic           overflow;
  logic           underflow;

  pc_sequencer #(
    .ADDR_WIDTH  (AW),
    .STACK_DEPTH (SD),
    .RESET_VECTOR(8'h10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .op       (op),
    .cond     (cond),
    .target   (target),
    .offset   (offset),
    .pc_out   (pc_out),
    .sp_out   (sp_out),
    .overflow (overflow),
    .underflow(underflow)
  );

  typedef struct {
    logic          rst;
    logic          en;
    logic [2:0]    op;
    logic          cond;
    logic [AW-1:0] target;
    logic [AW-1:0] offset;
    logic [AW-1:0] exp_pc;
    logic [31:0]   exp_sp;
    logic          exp_ovf;
    logic          exp_unf;
  } vec_t;

  vec_t vecs[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic add(input logic r, input logic e, input logic [2:0] o, input logic c,
                     input logic [AW-1:0] t, input logic [AW-1:0] off,
                     input logic [AW-1:0] epc, input int esp, input logic eo, input logic eu);
    vec_t v;
    v.rst = r; v.en = e; v.op = o; v.cond = c; v.target = t; v.offset = off;
    v.exp_pc = epc; v.exp_sp = 32'(esp); v.exp_ovf = eo; v.exp_unf = eu;
    vecs.push_back(v);
  endtask

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1ns after the rising edge
  task automatic step(input logic r, input logic e, input logic [2:0] o, input logic c,
                      input logic [AW-1:0] t, input logic [AW-1:0] off);
    @(negedge clk);
    rst = r; en = e; op = o; cond = c; target = t; offset = off;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [AW-1:0] epc, input int esp,
                           input logic eo, input logic eu);
    check({tag, " pc"},  32'(pc_out),    32'(epc));
    check({tag, " sp"},  32'(sp_out),    32'(esp));
    check({tag, " ovf"}, 32'(overflow),  32'(eo));
    check({tag, " unf"}, 32'(underflow), 32'(eu));
  endtask

  initial begin
    // reset, increment, wrap, relative and conditional branch, reserved ops, stall
    add(1, 1, INC,  0, 8'h00, 8'h00, 8'h10, 0, 0, 0);
    add(1, 1, INC,  0, 8'h00, 8'h00, 8'h10, 0, 0, 0);
    add(0, 1, INC,  0, 8'h00, 8'h00, 8'h11, 0, 0, 0);
    add(0, 1, INC,  0, 8'h00, 8'h00, 8'h12, 0, 0, 0);
    add(0, 1, INC,  0, 8'h00, 8'h00, 8'h13, 0, 0, 0);
    add(0, 1, JMP,  0, 8'hFE, 8'h00, 8'hFE, 0, 0, 0);
    add(0, 1, INC,  0, 8'h00, 8'h00, 8'hFF, 0, 0, 0);
    add(0, 1, INC,  0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    add(0, 1, BRR,  0, 8'h00, 8'hFC, 8'hFC, 0, 0, 0);
    add(0, 1, BRC,  0, 8'h00, 8'h03, 8'hFD, 0, 0, 0);
    add(0, 1, BRC,  1, 8'h00, 8'h03, 8'h00, 0, 0, 0);
    add(0, 1, RS6,  1, 8'h77, 8'h05, 8'h01, 0, 0, 0);
    add(0, 1, RS7,  1, 8'h77, 8'h05, 8'h02, 0, 0, 0);
    add(0, 0, JMP,  0, 8'h33, 8'h00, 8'h02, 0, 0, 0);
    add(0, 0, JMP,  0, 8'h33, 8'h00, 8'h02, 0, 0, 0);
    add(0, 0, JMP,  0, 8'h33, 8'h00, 8'h02, 0, 0, 0);
    add(0, 1, JMP,  0, 8'h20, 8'h00, 8'h20, 0, 0, 0);
`ifdef PC_SEQ_STACK_EN
    // nested calls, then overflow / underflow with sticky flags
    add(0, 1, CALL, 0, 8'h40, 8'h00, 8'h40, 1, 0, 0);
    add(0, 1, CALL, 0, 8'h60, 8'h00, 8'h60, 2, 0, 0);
    add(0, 1, RET,  0, 8'h00, 8'h00, 8'h41, 1, 0, 0);
    add(0, 1, RET,  0, 8'h00, 8'h00, 8'h21, 0, 0, 0);
    add(0, 1, JMP,  0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    add(0, 1, CALL, 0, 8'h80, 8'h00, 8'h80, 1, 0, 0);
    add(0, 1, CALL, 0, 8'h80, 8'h00, 8'h80, 2, 0, 0);
    add(0, 1, CALL, 0, 8'h80, 8'h00, 8'h80, 3, 0, 0);
    add(0, 1, CALL, 0, 8'h80, 8'h00, 8'h80, 4, 0, 0);
    add(0, 1, CALL, 0, 8'h80, 8'h00, 8'h80, 4, 1, 0);
    add(0, 1, RET,  0, 8'h00, 8'h00, 8'h81, 3, 1, 0);
    add(0, 1, RET,  0, 8'h00, 8'h00, 8'h81, 2, 1, 0);
    add(0, 1, RET,  0, 8'h00, 8'h00, 8'h81, 1, 1, 0);
    add(0, 1, RET,  0, 8'h00, 8'h00, 8'h01, 0, 1, 0);
    add(0, 1, RET,  0, 8'h00, 8'h00, 8'h02, 0, 1, 1);
    add(0, 0, CALL, 0, 8'h55, 8'h00, 8'h02, 0, 1, 1);
    add(0, 1, INC,  0, 8'h00, 8'h00, 8'h03, 0, 1, 1);
    add(1, 1, CALL, 0, 8'h55, 8'h00, 8'h10, 0, 0, 0);
    add(0, 1, CALL, 0, 8'h44, 8'h00, 8'h44, 1, 0, 0);
    add(0, 0, RET,  0, 8'h00, 8'h00, 8'h44, 1, 0, 0);
    add(0, 1, RET,  0, 8'h00, 8'h00, 8'h11, 0, 0, 0);
`else
    // CALL acts as JMP, RET as INC; stack outputs stay zero
    add(0, 1, CALL, 0, 8'h40, 8'h00, 8'h40, 0, 0, 0);
    add(0, 1, CALL, 0, 8'h60, 8'h00, 8'h60, 0, 0, 0);
    add(0, 1, RET,  0, 8'h00, 8'h00, 8'h61, 0, 0, 0);
    add(0, 1, RET,  0, 8'h00, 8'h00, 8'h62, 0, 0, 0);
    add(0, 1, JMP,  0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    add(0, 1, CALL, 0, 8'h80, 8'h00, 8'h80, 0, 0, 0);
    add(0, 1, CALL, 0, 8'h80, 8'h00, 8'h80, 0, 0, 0);
    add(0, 1, CALL, 0, 8'h80, 8'h00, 8'h80, 0, 0, 0);
    add(0, 1, CALL, 0, 8'h80, 8'h00, 8'h80, 0, 0, 0);
    add(0, 1, CALL, 0, 8'h80, 8'h00, 8'h80, 0, 0, 0);
    add(0, 1, RET,  0, 8'h00, 8'h00, 8'h81, 0, 0, 0);
    add(0, 1, RET,  0, 8'h00, 8'h00, 8'h82, 0, 0, 0);
    add(0, 1, RET,  0, 8'h00, 8'h00, 8'h83, 0, 0, 0);
    add(0, 1, RET,  0, 8'h00, 8'h00, 8'h84, 0, 0, 0);
    add(0, 1, RET,  0, 8'h00, 8'h00, 8'h85, 0, 0, 0);
    add(0, 0, CALL, 0, 8'h55, 8'h00, 8'h85, 0, 0, 0);
    add(0, 1, INC,  0, 8'h00, 8'h00, 8'h86, 0, 0, 0);
    add(1, 1, CALL, 0, 8'h55, 8'h00, 8'h10, 0, 0, 0);
    add(0, 1, CALL, 0, 8'h44, 8'h00, 8'h44, 0, 0, 0);
    add(0, 0, RET,  0, 8'h00, 8'h00, 8'h44, 0, 0, 0);
    add(0, 1, RET,  0, 8'h00, 8'h00, 8'h45, 0, 0, 0);
`endif

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].op, vecs[i].cond, vecs[i].target, vecs[i].offset);
      check_all($sformatf("vec%0d", i), vecs[i].exp_pc, int'(vecs[i].exp_sp),
                vecs[i].exp_ovf, vecs[i].exp_unf);
    end

    // interleaved call/return: a RET straight after a CALL must see the fresh push
`ifdef PC_SEQ_STACK_EN
    step(0, 1, CALL, 0, 8'h90, 8'h00); check_all("seq call90", 8'h90, 1, 0, 0);
    step(0, 1, CALL, 0, 8'hA0, 8'h00); check_all("seq callA0", 8'hA0, 2, 0, 0);
    step(0, 1, RET,  0, 8'h00, 8'h00); check_all("seq ret1",   8'h91, 1, 0, 0);
    step(0, 1, CALL, 0, 8'hB0, 8'h00); check_all("seq callB0", 8'hB0, 2, 0, 0);
    step(0, 1, RET,  0, 8'h00, 8'h00); check_all("seq ret2",   8'h92, 1, 0, 0);
    step(0, 1, RET,  0, 8'h00, 8'h00); check_all("seq ret3",   8'h12, 0, 0, 0);
`else
    step(0, 1, CALL, 0, 8'h90, 8'h00); check_all("seq call90", 8'h90, 0, 0, 0);
    step(0, 1, CALL, 0, 8'hA0, 8'h00); check_all("seq callA0", 8'hA0, 0, 0, 0);
    step(0, 1, RET,  0, 8'h00, 8'h00); check_all("seq ret1",   8'hA1, 0, 0, 0);
    step(0, 1, CALL, 0, 8'hB0, 8'h00); check_all("seq callB0", 8'hB0, 0, 0, 0);
    step(0, 1, RET,  0, 8'h00, 8'h00); check_all("seq ret2",   8'hB1, 0, 0, 0);
    step(0, 1, RET,  0, 8'h00, 8'h00); check_all("seq ret3",   8'hB2, 0, 0, 0);
`endif

    // reset dominates a deasserted enable
    step(0, 1, JMP, 0, 8'hC3, 8'h00); check_all("pre rst jmp", 8'hC3, 0, 0, 0);
    step(1, 0, JMP, 0, 8'h77, 8'h00); check_all("rst while stalled", 8'h10, 0, 0, 0);
    step(0, 1, BRR, 0, 8'h00, 8'h80); check_all("brr neg after rst", 8'h90, 0, 0, 0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer with relative branching, conditional branching and a hardware call/return stack. It supersedes the plain loadable program counter in the 8-bit processor's fetch stage. The control unit drives an operation code each cycle. The block supplies the registered instruction address to instruction memory.

## Interface
- `ADDR_WIDTH`, 8: width of the PC, target and offset buses; all address arithmetic is modulo 2^ADDR_WIDTH.
- `STACK_DEPTH`, 4: number of return-address entries; must be ≥ 1.
- `RESET_VECTOR`, 0: PC value loaded on reset.
- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  synchronous, active-high reset; dominates every other input.
- `en`  in  1  advance enable; 0 holds all state (stall).
- `op`  in  3  operation select (encoding below).
- `cond`  in  1  condition for BRC; ignored by other ops.
- `target`  in  ADDR_WIDTH  absolute destination for JMP/CALL.
- `offset`  in  ADDR_WIDTH  two's-complement signed displacement for BRR/BRC.
- `pc_out`  out  ADDR_WIDTH  current PC, registered.
- `sp_out`  out  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- `overflow`  out  1  sticky: a CALL was issued with the stack full.
- `underflow`  out  1  sticky: a RET was issued with the stack empty.

## Operation
- Op encoding:
  - 000 INC: pc ← pc+1.
  - 001 JMP: pc ← target.
  - 010 BRR: pc ← pc+offset.
  - 011 CALL: push pc+1, then pc ← target.
  - 100 RET: pc ← top of stack, then pop.
  - 101 BRC: pc ← pc+offset if cond=1, else pc+1.
  - 110/111: reserved, behave as INC.
- Arithmetic:
  - offset is sign-extended only conceptually; the sum is taken at ADDR_WIDTH bits and truncated.
  - 0xFF+1 → 0x00 and 0x02+0xFC → 0xFE (ADDR_WIDTH=8).
- Stack:
  - LIFO of STACK_DEPTH entries; sp_out counts valid entries (0…STACK_DEPTH).
  - CALL pushes to entry[sp] and increments sp.
  - RET reads entry[sp-1] and decrements sp.
- CALL with sp=STACK_DEPTH:
  - Jump is still taken; no push; sp unchanged; overflow ← 1.
  - Existing entries are untouched.
- RET with sp=0:
  - pc ← pc+1; sp stays 0; underflow ← 1.
- Sticky flags clear only on reset.
- en=0: pc, sp, stack contents and flags all hold; op, cond, target and offset are ignored.

## Timing
- Reset (rst=1 at a rising edge):
  - pc_out=RESET_VECTOR, sp_out=0, overflow=0, underflow=0.
  - Stack entry contents are don't-care.
- Reset asserted mid-operation (including during CALL/RET) wins; the op in that cycle has no effect.
- Latency:
  - An op sampled at edge N is reflected on pc_out and sp_out after edge N.
  - Flags update at the same edge.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Back-to-back ops are allowed every cycle.
- CALL at edge N followed by RET at edge N+1 returns to the pushed pc+1 (stack write is visible the next cycle).
- No RET-after-CALL bypass within a single cycle is needed; one op per cycle.

## Configuration
- `PC_SEQ_STACK_EN` defined: the call/return stack, sp_out, overflow and underflow are implemented as described.
- `PC_SEQ_STACK_EN` undefined:
  - No stack storage is built.
  - CALL behaves exactly as JMP; RET behaves exactly as INC.
  - sp_out, overflow and underflow are tied to 0.

## Test plan
- Reset and increment (RESET_VECTOR=0x10): hold rst for 2 cycles, release, INC ×3 → pc_out=0x10, then 0x11, 0x12, 0x13; sp_out=0, flags 0.
- Wrap and relative branch:
  - JMP target=0xFE, INC, INC → 0xFE, 0xFF, 0x00.
  - BRR offset=0xFC from 0x00 → 0xFC.
  - BRC cond=0 → 0xFD; BRC cond=1, offset=0x03 → 0x00.
- Nested calls (macro on, STACK_DEPTH=4):
  - From 0x20: CALL 0x40, CALL 0x60 → sp_out=2.
  - RET → 0x41; RET → 0x21; sp_out=0.
- Overflow/underflow:
  - 5 CALLs to 0x80 starting at pc=0x00 → sp_out=4 and overflow=1 after the 5th.
  - 4 RETs → 0x81, 0x81, 0x81, 0x01.
  - 5th RET → pc 0x02, underflow=1; both flags stay high until rst.
- Stall and reset mid-operation:
  - en=0 for 3 cycles while op=JMP 0x33 → pc_out and sp_out unchanged.
  - rst=1 together with a CALL → pc_out=RESET_VECTOR, sp_out=0, flags 0.
- Macro off: CALL 0x40 → pc 0x40, sp_out=0; RET → 0x41; flags stay 0.
